// File: rtl/neuron_mac_1_35.sv
// Pipelined fixed-point neuron MAC: input x weight, saturating accumulate,
// then bias add, rescale and clamp to one signed output word per vector.
module neuron_mac_1_35 #(
   parameter int layerNo      = 1,
   parameter int neuronNo     = 35,
   parameter int numWeight    = 784,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16,
   parameter int fracBits     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [dataWidth-1:0] myinput,
   input  logic                        myinputValid,
   input  logic signed [dataWidth-1:0] biasIn,
   output logic                        ren,
   output logic [addressWidth:0]       raddr,
   input  logic signed [dataWidth-1:0] wout,
   output logic signed [dataWidth-1:0] out,
   output logic                        outvalid
);

   localparam int AW = 2 * dataWidth;
   localparam logic [addressWidth:0] LastIdx = (addressWidth + 1)'(numWeight - 1);
   localparam logic signed [AW-1:0] AccMax = {1'b0, {(AW - 1){1'b1}}};
   localparam logic signed [AW-1:0] AccMin = {1'b1, {(AW - 1){1'b0}}};
   localparam logic signed [AW-1:0] OutMax =
      {{(dataWidth + 1){1'b0}}, {(dataWidth - 1){1'b1}}};
   localparam logic signed [AW-1:0] OutMin =
      {{(dataWidth + 1){1'b1}}, {(dataWidth - 1){1'b0}}};

   if (numWeight < 1 || numWeight > 2 ** (addressWidth + 1) ||
       layerNo < 0 || neuronNo < 0) begin : g_bad_cfg
      $error("neuron_mac_1_35: inconsistent parameters");
   end

   function automatic logic signed [AW-1:0] sat_add(
      input logic signed [AW-1:0] a,
      input logic signed [AW-1:0] b
   );
      logic signed [AW-1:0] s;
      s = a + b;
      if (!a[AW-1] && !b[AW-1] && s[AW-1]) return AccMax;
      if (a[AW-1] && b[AW-1] && !s[AW-1]) return AccMin;
      return s;
   endfunction

   logic [addressWidth:0]        idx;
   logic signed [dataWidth-1:0]  x_d;
   logic                         v0, last0;
   logic signed [AW-1:0]         prod;
   logic                         v1, last1;
   logic signed [AW-1:0]         acc, sum2;
   logic                         v2;

   logic signed [AW-1:0]         acc_sum, bias_ext, biased, shifted;
   logic signed [dataWidth-1:0]  res;

   assign ren   = myinputValid;
   assign raddr = idx;

   always_comb begin
      acc_sum  = sat_add(acc, prod);
      bias_ext = AW'(biasIn) <<< fracBits;
      biased   = sat_add(sum2, bias_ext);
      shifted  = biased >>> fracBits;
      res      = shifted[dataWidth-1:0];
      if (shifted > OutMax)
         res = {1'b0, {(dataWidth - 1){1'b1}}};
      else if (shifted < OutMin)
         res = {1'b1, {(dataWidth - 1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx      <= '0;
         x_d      <= '0;
         v0       <= 1'b0;
         last0    <= 1'b0;
         prod     <= '0;
         v1       <= 1'b0;
         last1    <= 1'b0;
         acc      <= '0;
         sum2     <= '0;
         v2       <= 1'b0;
         out      <= '0;
         outvalid <= 1'b0;
      end else begin
         // x_d lines up with the weight read issued on the same edge
         if (myinputValid) begin
            idx   <= (idx == LastIdx) ? '0 : idx + 1'b1;
            x_d   <= myinput;
            last0 <= (idx == LastIdx);
         end
         v0 <= myinputValid;

         if (v0) begin
            prod  <= x_d * wout;
            last1 <= last0;
         end
         v1 <= v0;

         // closing a vector hands off the sum and restarts acc at once
         if (v1) begin
            if (last1) begin
               sum2 <= acc_sum;
               acc  <= '0;
            end else begin
               acc <= acc_sum;
            end
         end
         v2 <= v1 && last1;

         if (v2) out <= res;
         outvalid <= v2;
      end
   end

endmodule

// File: tb/tb_neuron_mac_1_35.sv
// Scoreboard bench for neuron_mac_1_35 with a 4-weight memory model
// and a plain-arithmetic reference of the neuron computation.
module tb_neuron_mac_1_35;

   localparam int NW = 4;
   localparam int DW = 16;
   localparam int FB = 8;
   localparam int ABW = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic signed [DW-1:0] myinput = '0;
   logic myinputValid = 1'b0;
   logic signed [DW-1:0] biasIn = '0;
   logic ren;
   logic [ABW:0] raddr;
   logic signed [DW-1:0] wout = '0;
   logic signed [DW-1:0] out;
   logic outvalid;

   always #5 clk = ~clk;

   neuron_mac_1_35 #(
      .layerNo(1), .neuronNo(35), .numWeight(NW),
      .addressWidth(ABW), .dataWidth(DW), .fracBits(FB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .myinput(myinput),
      .myinputValid(myinputValid), .biasIn(biasIn),
      .ren(ren), .raddr(raddr), .wout(wout),
      .out(out), .outvalid(outvalid)
   );

   logic signed [DW-1:0] mem [NW];
   always @(posedge clk) if (ren) wout <= mem[raddr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      logic signed [DW-1:0] v;
   } exp_t;

   exp_t eq[$];
   exp_t bq[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: pops expected results whenever the DUT presents one
   logic signed [DW-1:0] hold_v = '0;
   bit hold_ok = 1'b0;
   always @(negedge clk) begin
      if (outvalid === 1'b1) begin
         if (eq.size() == 0) begin
            chk("stray_outvalid", 32'(outvalid), 32'd0);
         end else begin
            exp_t e;
            e = eq.pop_front();
            chk("out", 32'(out), 32'(e.v));
            chk("latency", 32'(cyc), 32'(e.due));
         end
         hold_v = out;
         hold_ok = 1'b1;
      end else if (hold_ok) begin
         chk("out_hold", 32'(out), 32'(hold_v));
      end
      if (!rst_n) hold_ok = 1'b0;
   end

   // reference model state
   int midx = 0;
   longint macc = 0;
   logic signed [DW-1:0] cur_bias = '0;

   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   task automatic cyc_step();
      @(posedge clk);
      #1;
      while (bq.size() > 0 && bq[0].due <= cyc) void'(bq.pop_front());
      biasIn = (bq.size() > 0) ? bq[0].v : cur_bias;
      myinputValid = 1'b0;
   endtask

   task automatic send(input logic signed [DW-1:0] x);
      longint r;
      cyc_step();
      myinput = x;
      myinputValid = 1'b1;
      #1;
      chk("ren", 32'(ren), 32'd1);
      chk("raddr", 32'(raddr), 32'(midx));
      macc = sat32(macc + longint'(x) * longint'(mem[midx]));
      if (midx == NW - 1) begin
         r = sat32(macc + longint'(cur_bias) * (64'sd1 <<< FB));
         r = r >>> FB;
         if (r > 32767) r = 32767;
         if (r < -32768) r = -32768;
         eq.push_back('{cyc + 4, DW'(r)});
         bq.push_back('{cyc + 4, cur_bias});
         macc = 0;
      end
      midx = (midx + 1) % NW;
   endtask

   task automatic send_gap(input logic signed [DW-1:0] x,
                           input int gmin, input int gmax);
      repeat ($urandom_range(gmax, gmin)) cyc_step();
      send(x);
   endtask

   task automatic drain();
      repeat (8) cyc_step();
   endtask

   task automatic set_mem(input logic signed [DW-1:0] w);
      for (int i = 0; i < NW; i++) mem[i] = w;
   endtask

   task automatic basic_vec(input int gmin, input int gmax);
      cur_bias = 16'sh0080;
      for (int i = 1; i <= NW; i++) send_gap(DW'(i * 256), gmin, gmax);
   endtask

   task automatic mid_reset();
      cyc_step();
      rst_n = 1'b0;
      myinput = DW'($urandom);
      myinputValid = 1'b1;
      #1;
      chk("ren_in_reset", 32'(ren), 32'd1);
      cyc_step();
      rst_n = 1'b1;
      midx = 0;
      macc = 0;
   endtask

   initial begin
      set_mem('0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_outvalid", 32'(outvalid), 32'd0);
      chk("rst_raddr", 32'(raddr), 32'd0);
      chk("rst_ren", 32'(ren), 32'd0);
      cyc_step();
      rst_n = 1'b1;
      cyc_step();

      set_mem(16'sh0100);
      basic_vec(0, 0);
      drain();

      basic_vec(1, 3);
      drain();

      basic_vec(0, 0);
      cur_bias = '0;
      for (int i = 0; i < NW; i++) send(16'sh0100);
      drain();

      set_mem(16'sh7FFF);
      cur_bias = '0;
      for (int i = 0; i < NW; i++) send(16'sh7FFF);
      drain();
      for (int i = 0; i < NW; i++) send(16'sh8000);
      drain();

      set_mem(16'sh0100);
      cur_bias = 16'sh0080;
      send(16'sh0100);
      send(16'sh0200);
      mid_reset();
      basic_vec(0, 0);
      drain();

      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
         for (int v = 0; v < 5; v++) begin
            cur_bias = DW'($urandom);
            for (int i = 0; i < NW; i++)
               send_gap(DW'($urandom), 0, (b % 2 == 1) ? 2 : 0);
         end
         drain();
      end

      for (int k = 0; k < 20 && eq.size() > 0; k++) cyc_step();
      chk("queue_empty", 32'(eq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/neuron_mac_1_35.md
NEURON_MAC_1_35 -- requirements
Module: neuron_mac_1_35

Interface
REQ-001 Parameters SHALL be:
- layerNo, default 1, layer index.
- neuronNo, default 35, neuron index.
- numWeight, default 784, weights per input vector.
- addressWidth, default 10, weight address width, less 1.
- dataWidth, default 16, signed word width.
- fracBits, default 8, fractional bits of the fixed-point format.
REQ-002 Ports SHALL be:
- clk, input, 1, sole clock; all logic on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- myinput, input, dataWidth, signed input sample.
- myinputValid, input, 1, myinput valid this cycle.
- biasIn, input, dataWidth, signed bias; held stable while a vector is in flight.
- ren, output, 1, weight memory read enable.
- raddr, output, addressWidth+1, weight memory read address.
- wout, input, dataWidth, signed weight from memory, valid one cycle after ren.
- out, output, dataWidth, signed neuron pre-activation result.
- outvalid, output, 1, one-cycle pulse, out valid.
REQ-003 Clock and reset SHALL be exactly: one clock (clk); reset rst_n is synchronous and active-low.

Function
REQ-004 ren SHALL equal myinputValid combinationally.
REQ-005 raddr SHALL be driven directly from the registered index counter idx.
REQ-006 idx SHALL increment on each cycle with myinputValid=1, and SHALL wrap from numWeight-1 to 0.
REQ-007 Idle cycles (myinputValid=0) SHALL be allowed anywhere; idx and the pipeline hold data and do not advance a sample.
REQ-008 The block SHALL register myinput, plus a last flag (idx==numWeight-1), at the accepting edge, aligned with wout on the next cycle.
REQ-009 Stage 1: product = myinput_d * wout, signed, 2*dataWidth bits, registered together with valid and last.
REQ-010 Stage 2: the accumulator acc (2*dataWidth, signed) SHALL add each valid product with saturating addition.
REQ-011 Saturating addition SHALL clamp to +max when both operands are non-negative and the sum is negative, and to -min when both are negative and the sum is non-negative.
REQ-012 When a last product is added, the saturated sum SHALL be passed to stage 3 and acc SHALL clear to 0 in the same cycle.
REQ-013 Back-to-back vectors SHALL need no gap cycles.
REQ-014 Stage 3: the result SHALL be saturate_add(sum, sign-extended biasIn <<< fracBits), then arithmetic shift right by fracBits, then saturated to dataWidth (clamp to 0x7FFF / 0x8000 for dataWidth=16).
REQ-015 The stage 3 result SHALL be registered into out, with outvalid=1 for exactly one cycle.
REQ-016 Latency: if the last sample is accepted at edge T, outvalid SHALL be high in the cycle after edge T+3, i.e. 4 cycles after the last valid cycle.
REQ-017 out SHALL hold its value until the next outvalid.
REQ-018 State SHALL be the counter plus pipeline valid bits only; no other FSM states exist.

Reset
REQ-019 With rst_n=0 at an edge, the block SHALL clear idx, acc, all pipeline valid/last flags, out=0 and outvalid=0.
REQ-020 Reset mid-vector SHALL discard the partial sum; no outvalid SHALL result from pre-reset samples.
REQ-021 During reset, ren SHALL still follow myinputValid, but the accepted sample SHALL be discarded.

Verification (numWeight=4, dataWidth=16, fracBits=8, memory model with 1-cycle read latency)
REQ-022 Basic vector: weights 0x0100 x4, inputs 0x0100, 0x0200, 0x0300, 0x0400, bias 0x0080 -> raddr 0,1,2,3; out=0x0A80; single outvalid 4 cycles after the last valid.
REQ-023 Gapped input: same data with 1-3 idle cycles between samples -> same out=0x0A80; raddr advances only on valid.
REQ-024 Back-to-back vectors: second vector inputs 0x0100 x4, weights 0x0100, bias 0 -> two outvalid pulses exactly 4 cycles apart, outs 0x0A80 then 0x0400.
REQ-025 Saturation: weights 0x7FFF, inputs 0x7FFF, bias 0 -> out=0x7FFF; inputs 0x8000 -> out=0x8000.
REQ-026 Reset mid-vector: 2 samples, rst_n=0 for one cycle, then the full REQ-022 vector -> raddr restarts at 0; exactly one outvalid; out=0x0A80.
REQ-027 Reset values: after reset with no input -> out=0, outvalid=0, raddr=0, ren=0.
